// File: rtl/ad9152_dma_upack.sv
// DMA-to-DAC unpacker: buffers 128-bit DMA words in a small FIFO and hands
// them out as 64-bit per-channel sample groups in dual or single-channel mode.
module ad9152_dma_upack #(
    parameter int FIFO_ADDR_WIDTH = 2
) (
    input  logic         dac_clk,
    input  logic         dac_rstn,
    input  logic         dma_valid,
    output logic         dma_ready,
    input  logic [127:0] dma_data,
    input  logic         dac_valid_0,
    input  logic         dac_valid_1,
    input  logic         dac_enable_0,
    input  logic         dac_enable_1,
    output logic [63:0]  dac_ddata_0,
    output logic [63:0]  dac_ddata_1,
    output logic         dac_dunf
);

    localparam int              DEPTH   = 1 << FIFO_ADDR_WIDTH;
    localparam int              CW      = FIFO_ADDR_WIDTH + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_CH0  = 2'b01,
        MODE_CH1  = 2'b10,
        MODE_DUAL = 2'b11
    } mode_t;

    logic [127:0]               mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]              count;
    logic                       half;
    logic                       ready_en;
    mode_t                      mode_q;

    mode_t                      mode;
    logic                       push;
    logic                       strobe;
    logic                       changed;
    logic                       discard;
    logic [FIFO_ADDR_WIDTH-1:0] eff_rd;
    logic [CW-1:0]              eff_cnt;
    logic                       eff_half;
    logic [127:0]               head;
    logic [63:0]                sel;

    logic                       pop;
    logic                       half_n;
    logic [63:0]                ddata_0_n;
    logic [63:0]                ddata_1_n;
    logic                       dunf_n;

    assign mode      = mode_t'({dac_enable_1, dac_enable_0});
    assign dma_ready = ready_en && (count < DEPTH_C);
    assign push      = dma_valid && dma_ready;
    assign strobe    = dac_valid_0 || dac_valid_1;

    // A mode switch abandons a half-consumed head word; the strobe in the same
    // cycle is then served from the word behind it.
    assign changed  = (mode != mode_q);
    assign discard  = changed && half && (count != '0);
    assign eff_rd   = rd_ptr + FIFO_ADDR_WIDTH'(discard);
    assign eff_cnt  = count - CW'(discard);
    assign eff_half = half && !changed;
    assign head     = mem[eff_rd];
    assign sel      = eff_half ? head[127:64] : head[63:0];

    // NOTE: every output of this block gets a default first, so no path
    // through the branches leaves a variable unassigned and no latch is inferred.
    always_comb begin
        pop       = 1'b0;
        half_n    = eff_half;
        ddata_0_n = dac_ddata_0;
        ddata_1_n = dac_ddata_1;
        dunf_n    = 1'b0;
        if (mode == MODE_IDLE) begin
            half_n    = 1'b0;
            ddata_0_n = '0;
            ddata_1_n = '0;
        end else if (strobe) begin
            if (eff_cnt == '0) begin
                ddata_0_n = '0;
                ddata_1_n = '0;
                dunf_n    = 1'b1;
            end else if (mode == MODE_DUAL) begin
                ddata_0_n = head[63:0];
                ddata_1_n = head[127:64];
                pop       = 1'b1;
            end else begin
                ddata_0_n = (mode == MODE_CH0) ? sel : '0;
                ddata_1_n = (mode == MODE_CH1) ? sel : '0;
                pop       = eff_half;
                half_n    = !eff_half;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge dac_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            half        <= 1'b0;
            ready_en    <= 1'b0;
            mode_q      <= MODE_IDLE;
            dac_ddata_0 <= '0;
            dac_ddata_1 <= '0;
            dac_dunf    <= 1'b0;
        end else begin
            ready_en    <= 1'b1;
            mode_q      <= mode;
            half        <= half_n;
            dac_ddata_0 <= ddata_0_n;
            dac_ddata_1 <= ddata_1_n;
            dac_dunf    <= dunf_n;
            if (mode == MODE_IDLE) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(push);
                rd_ptr <= eff_rd + FIFO_ADDR_WIDTH'(pop);
                count  <= eff_cnt - CW'(pop) + CW'(push);
            end
        end
    end

    // NOTE: the storage array is not reset; count and pointers define which
    // entries are valid, so stale contents are never observed.
    always_ff @(posedge dac_clk) begin
        if (push && (mode != MODE_IDLE)) begin
            mem[wr_ptr] <= dma_data;
        end
    end

endmodule

// File: tb/tb_ad9152_dma_upack.sv
// Randomized and directed bench for ad9152_dma_upack against a queue-based
// reference model of the unpacking rules.
module tb_ad9152_dma_upack;

    localparam int FAW   = 2;
    localparam int DEPTH = 1 << FAW;

    logic         dac_clk = 1'b0;
    logic         dac_rstn = 1'b0;
    logic         dma_valid = 1'b0;
    logic         dma_ready;
    logic [127:0] dma_data = '0;
    logic         dac_valid_0 = 1'b0;
    logic         dac_valid_1 = 1'b0;
    logic         dac_enable_0 = 1'b0;
    logic         dac_enable_1 = 1'b0;
    logic [63:0]  dac_ddata_0;
    logic [63:0]  dac_ddata_1;
    logic         dac_dunf;

    ad9152_dma_upack #(.FIFO_ADDR_WIDTH(FAW)) dut (
        .dac_clk      (dac_clk),
        .dac_rstn     (dac_rstn),
        .dma_valid    (dma_valid),
        .dma_ready    (dma_ready),
        .dma_data     (dma_data),
        .dac_valid_0  (dac_valid_0),
        .dac_valid_1  (dac_valid_1),
        .dac_enable_0 (dac_enable_0),
        .dac_enable_1 (dac_enable_1),
        .dac_ddata_0  (dac_ddata_0),
        .dac_ddata_1  (dac_ddata_1),
        .dac_dunf     (dac_dunf)
    );

    always #5 dac_clk = ~dac_clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [127:0] q[$];
    bit           m_half;
    logic [1:0]   m_mode;
    bit           m_started;
    logic [63:0]  m_o0;
    logic [63:0]  m_o1;
    bit           m_dunf;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] fw(input int i);
        return {64'h0000_0000_0000_A000 + 64'(i), 64'h0000_0000_0000_B000 + 64'(i)};
    endfunction

    task automatic model_reset();
        q.delete();
        m_half    = 1'b0;
        m_mode    = 2'b00;
        m_started = 1'b0;
        m_o0      = '0;
        m_o1      = '0;
        m_dunf    = 1'b0;
    endtask

    // One clock edge of the unpacking rules, using the inputs sampled at the edge.
    task automatic model_edge();
        logic [1:0]   mode;
        bit           strobe;
        bit           push;
        bit           changed;
        logic [127:0] w;
        logic [63:0]  sample;
        mode    = {dac_enable_1, dac_enable_0};
        strobe  = dac_valid_0 || dac_valid_1;
        push    = dma_valid && m_started && (q.size() < DEPTH);
        changed = (mode != m_mode);
        m_started = 1'b1;
        m_mode    = mode;
        m_dunf    = 1'b0;
        if (mode == 2'b00) begin
            q.delete();
            m_half = 1'b0;
            m_o0   = '0;
            m_o1   = '0;
        end else begin
            if (changed) begin
                if (m_half && q.size() > 0) w = q.pop_front();
                m_half = 1'b0;
            end
            if (strobe) begin
                if (q.size() == 0) begin
                    m_o0   = '0;
                    m_o1   = '0;
                    m_dunf = 1'b1;
                end else if (mode == 2'b11) begin
                    w    = q.pop_front();
                    m_o0 = w[63:0];
                    m_o1 = w[127:64];
                end else begin
                    w      = q[0];
                    sample = m_half ? w[127:64] : w[63:0];
                    if (m_half) w = q.pop_front();
                    m_half = !m_half;
                    m_o0   = (mode == 2'b01) ? sample : 64'd0;
                    m_o1   = (mode == 2'b10) ? sample : 64'd0;
                end
            end
            if (push) q.push_back(dma_data);
        end
    endtask

    // Called just after a falling edge: drive, clock, then compare against the model.
    task automatic cycle(input bit v, input logic [127:0] d, input bit s, input logic [1:0] en);
        logic [1:0] r;
        r            = 2'($urandom_range(1, 3));
        dma_valid    = v;
        dma_data     = d;
        dac_valid_0  = s & r[0];
        dac_valid_1  = s & r[1];
        dac_enable_0 = en[0];
        dac_enable_1 = en[1];
        @(posedge dac_clk);
        model_edge();
        #1;
        check("ddata_0", 128'(dac_ddata_0), 128'(m_o0));
        check("ddata_1", 128'(dac_ddata_1), 128'(m_o1));
        check("dunf", 128'(dac_dunf), 128'(m_dunf));
        check("ready", 128'(dma_ready), 128'(m_started && (q.size() < DEPTH)));
        @(negedge dac_clk);
    endtask

    task automatic do_reset();
        dac_rstn = 1'b0;
        #1;
        model_reset();
        check("rst_ddata_0", 128'(dac_ddata_0), 128'd0);
        check("rst_ddata_1", 128'(dac_ddata_1), 128'd0);
        check("rst_dunf", 128'(dac_dunf), 128'd0);
        check("rst_ready", 128'(dma_ready), 128'd0);
        @(negedge dac_clk);
        @(negedge dac_clk);
        dac_rstn = 1'b1;
    endtask

    initial begin
        logic [1:0] en;
        model_reset();
        #2;
        check("por_ddata_0", 128'(dac_ddata_0), 128'd0);
        check("por_ddata_1", 128'(dac_ddata_1), 128'd0);
        check("por_dunf", 128'(dac_dunf), 128'd0);
        check("por_ready", 128'(dma_ready), 128'd0);
        @(negedge dac_clk);
        @(negedge dac_clk);
        dac_rstn = 1'b1;
        cycle(0, '0, 0, 2'b00);
        check("ready_after_release", 128'(dma_ready), 128'd1);

        // Dual mode: two words out on consecutive strobes, then underflow
        cycle(1, {64'h1111_1111_1111_1111, 64'h0}, 0, 2'b11);
        cycle(1, {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222}, 0, 2'b11);
        cycle(0, '0, 1, 2'b11);
        check("dual_w0_ch0", 128'(dac_ddata_0), 128'd0);
        check("dual_w0_ch1", 128'(dac_ddata_1), 128'(64'h1111_1111_1111_1111));
        cycle(0, '0, 1, 2'b11);
        check("dual_w1_ch0", 128'(dac_ddata_0), 128'(64'h2222_2222_2222_2222));
        check("dual_w1_ch1", 128'(dac_ddata_1), 128'(64'h3333_3333_3333_3333));
        cycle(0, '0, 1, 2'b11);

        // CH0: lower, upper, underflow
        cycle(1, {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB}, 0, 2'b01);
        cycle(0, '0, 1, 2'b01);
        check("ch0_lo", 128'(dac_ddata_0), 128'(64'hBBBB_BBBB_BBBB_BBBB));
        check("ch0_lo_ch1", 128'(dac_ddata_1), 128'd0);
        cycle(0, '0, 1, 2'b01);
        check("ch0_hi", 128'(dac_ddata_0), 128'(64'hAAAA_AAAA_AAAA_AAAA));
        cycle(0, '0, 1, 2'b01);
        check("ch0_unf_data", 128'(dac_ddata_0), 128'd0);
        check("ch0_unf_dunf", 128'(dac_dunf), 128'd1);

        // Fill to full, then one dual pop reopens ready
        for (int i = 0; i < 5; i++) cycle(1, fw(i), 0, 2'b11);
        check("full_ready", 128'(dma_ready), 128'd0);
        cycle(0, '0, 1, 2'b11);
        check("pop_ch1", 128'(dac_ddata_1), 128'(fw(0) >> 64));
        check("reopen_ready", 128'(dma_ready), 128'd1);

        // CH1 with half=1, switch to dual: head word dropped
        cycle(0, '0, 1, 2'b10);
        check("ch1_lo", 128'(dac_ddata_1), 128'(64'hB001));
        cycle(0, '0, 0, 2'b11);
        cycle(0, '0, 1, 2'b11);
        check("switch_ch0", 128'(dac_ddata_0), 128'(64'hB002));
        check("switch_ch1", 128'(dac_ddata_1), 128'(64'hA002));

        // Idle with three words buffered flushes everything
        cycle(1, fw(4), 0, 2'b11);
        cycle(1, fw(5), 0, 2'b11);
        cycle(0, '0, 1, 2'b00);
        check("idle_ch0", 128'(dac_ddata_0), 128'd0);
        check("idle_dunf", 128'(dac_dunf), 128'd0);
        check("idle_ready", 128'(dma_ready), 128'd1);
        cycle(1, fw(6), 1, 2'b00);
        cycle(0, '0, 1, 2'b11);
        check("idle_flushed", 128'(dac_dunf), 128'd1);

        // Reset mid-stream with two words buffered
        cycle(1, fw(7), 0, 2'b11);
        cycle(1, fw(8), 0, 2'b11);
        cycle(1, fw(9), 1, 2'b11);
        do_reset();
        cycle(0, '0, 1, 2'b11);
        check("post_rst_dunf", 128'(dac_dunf), 128'd1);

        // Randomized traffic
        en = 2'b11;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 11) == 0) en = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle(1'($urandom_range(0, 1)),
                  {$urandom(), $urandom(), $urandom(), $urandom()},
                  1'($urandom_range(0, 1)), en);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ad9152_dma_upack.md
AD9152_DMA_UPACK -- requirements
Module: ad9152_dma_upack

Interface
REQ-001 Parameter FIFO_ADDR_WIDTH, default 2, meaning FIFO depth = 2^FIFO_ADDR_WIDTH words of 128 bits; legal values 1..4.
REQ-002 dac_clk  input  1  sole clock; every register is clocked on its rising edge.
REQ-003 dac_rstn  input  1  reset; asynchronous assert, active-low.
REQ-004 dma_valid  input  1  DMA word valid.
REQ-005 dma_ready  output  1  block accepts dma_data this cycle.
REQ-006 dma_data  input  128  DMA word; bits [63:0] are the lower half, bits [127:64] the upper half.
REQ-007 dac_valid_0, dac_valid_1  input  1 each  DAC sample strobes; strobe = dac_valid_0 OR dac_valid_1.
REQ-008 dac_enable_0, dac_enable_1  input  1 each  channel enables.
REQ-009 dac_ddata_0, dac_ddata_1  output  64 each  four 16-bit samples per channel, registered.
REQ-010 dac_dunf  output  1  underflow pulse, registered.

Function
REQ-011 A DMA word SHALL be written into the FIFO when dma_valid=1 and dma_ready=1 in the same cycle.
REQ-012 dma_ready SHALL be 1 when FIFO count < depth and SHALL be derived from registered state only, with no combinational path from dma_valid or the strobes.
REQ-013 A written word SHALL be readable no earlier than the next cycle; there is no bypass path.
REQ-014 Mode SHALL be decoded from {dac_enable_1, dac_enable_0}: 11 = DUAL, 01 = CH0, 10 = CH1, 00 = IDLE.
REQ-015 DUAL mode, strobe with count > 0: pop one word; next cycle dac_ddata_0 = word[63:0] and dac_ddata_1 = word[127:64].
REQ-016 Single-channel mode uses a half pointer, reset value 0.
- Strobe with half=0 and count > 0: drive word[63:0] to the enabled channel, do not pop, set half=1.
- Strobe with half=1: drive word[127:64], pop, set half=0.
- The disabled channel output SHALL be 0.
REQ-017 Underflow: strobe with count = 0 in DUAL, CH0 or CH1 mode SHALL produce, next cycle, both data outputs = 0 and dac_dunf = 1 for one cycle; the half pointer is unchanged.
REQ-018 A cycle without a strobe SHALL hold dac_ddata_0/1 at their previous values and drive dac_dunf = 0.
REQ-019 IDLE mode:
- FIFO count forced to 0 and half forced to 0.
- dma_ready = 1; accepted words are discarded.
- Outputs 0; dac_dunf = 0.
REQ-020 Mode change: a registered copy of the mode SHALL be compared each cycle. On mismatch, the half pointer clears, the FIFO head word is popped if half was 1, and any strobe in that cycle is served under the new mode.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; the read and write pointers wrap modulo depth.
REQ-022 Full FIFO: dma_ready = 0. A pop in the same cycle does not enable a push until the next cycle.
REQ-023 Count SHALL be FIFO_ADDR_WIDTH+1 bits wide and never exceed depth or go below 0.

Reset
REQ-024 While dac_rstn = 0:
- count, pointers, half and registered mode = 0.
- dac_ddata_0/1 = 0; dac_dunf = 0; dma_ready = 0.
REQ-025 dma_ready SHALL assert on the first rising edge after dac_rstn deasserts, with FIFO empty.
REQ-026 Reset asserted mid-operation SHALL discard all buffered data immediately (asynchronous), with no further output updates until release.

Verification
REQ-027 DUAL mode, push words W0 = {64'h1111..., 64'h0000...} and W1; strobe every cycle -> ch0/ch1 show W0 halves, then W1 halves, on consecutive cycles; dac_dunf = 0.
REQ-028 CH0 mode, push one word 128'hAAAA...BBBB; three strobes -> ch0 = lower half, then upper half, then 0 with dac_dunf = 1; ch1 = 0 throughout.
REQ-029 FIFO_ADDR_WIDTH = 2, no strobes, dma_valid held 1 -> exactly 4 words accepted, then dma_ready = 0. One strobe in DUAL mode -> dma_ready = 1 the following cycle.
REQ-030 CH1 mode with half = 1, switch enables to DUAL -> head word discarded; next strobe outputs the following word on both channels.
REQ-031 Enables = 00 with 3 words buffered -> count = 0 next cycle, dma_ready = 1, outputs 0, no dac_dunf on strobes.
REQ-032 Assert dac_rstn = 0 mid-stream with 2 words buffered -> outputs 0 asynchronously. After release, a strobe with no push gives dac_dunf = 1.
